// File: rtl/frame_fetch_ctrl.sv
// frame_fetch_ctrl: issues DRAM line-read bursts into the pixel FIFO.
// Ports: clk/rst (sync, low), frame_start/line_req pulses, writer buffer
// handoff (wr_buf_done/wr_buf_idx), fifo_level/buf_we credit inputs,
// kick/busy request handshake with read_addr/read_num, and status
// outputs rd_buf_idx, line_idx, drop_cnt.
module frame_fetch_ctrl #(
  parameter int          X_SIZE       = 1600,
  parameter int          Y_SIZE       = 900,
  parameter int          NUM_BUFS     = 2,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
  parameter logic [31:0] FRAME_STRIDE = 32'h0060_0000,
  parameter int          MAX_BURST    = 256,
  parameter int          FIFO_DEPTH   = 8192,
  localparam int         BUF_W        =
    (NUM_BUFS > 2) ? $clog2(NUM_BUFS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             frame_start,
  input  logic             line_req,
  input  logic             wr_buf_done,
  input  logic [BUF_W-1:0] wr_buf_idx,
  input  logic [15:0]      fifo_level,
  input  logic             buf_we,
  output logic             kick,
  input  logic             busy,
  output logic [31:0]      read_addr,
  output logic [31:0]      read_num,
  output logic [BUF_W-1:0] rd_buf_idx,
  output logic [11:0]      line_idx,
  output logic [15:0]      drop_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_CREDIT,
    KICK,
    WAIT_BUSY_LOW
  } state_t;

  localparam logic [11:0] Y_END = 12'(Y_SIZE);
  localparam logic [31:0] X_W   = 32'(X_SIZE);
  localparam logic [31:0] MAX_W = 32'(MAX_BURST);
  localparam logic [31:0] DEP_W = 32'(FIFO_DEPTH);

  state_t           state, state_d;
  logic             kick_d;
  logic [31:0]      addr_d, num_d;
  logic [BUF_W-1:0] rd_d;
  logic [11:0]      line_d;
  logic [15:0]      drop_d;

  logic [31:0]      offset, off_d;
  logic [16:0]      pending, pend_d;
  logic [1:0]       queue, q_d;
  logic [BUF_W-1:0] newest_idx, newest_d;
  logic             new_valid, nv_d;
  logic             abort, abort_d;
  logic             accept;

  logic [31:0] used, credit, remain, burst;
  logic [31:0] line_addr, off_sum;

  // burst sizing and address of the next chunk of the current line
  always_comb begin
    used   = 32'(fifo_level) + 32'(pending);
    credit = (used >= DEP_W) ? '0 : DEP_W - used;
    remain = X_W - offset;
    burst  = MAX_W;
    if (remain < burst) burst = remain;
    if (credit < burst) burst = credit;
    line_addr = BASE_ADDR
              + 32'(rd_buf_idx) * FRAME_STRIDE
              + ((32'(line_idx) * X_W + offset) << 2);
    off_sum = offset + read_num;
  end

  always_comb begin
    state_d  = state;
    kick_d   = kick;
    addr_d   = read_addr;
    num_d    = read_num;
    rd_d     = rd_buf_idx;
    line_d   = line_idx;
    drop_d   = drop_cnt;
    off_d    = offset;
    q_d      = queue;
    newest_d = newest_idx;
    nv_d     = new_valid;
    abort_d  = abort;
    accept   = 1'b0;

    if (wr_buf_done) begin
      newest_d = wr_buf_idx;
      nv_d     = 1'b1;
    end

    // a buffer finishing on the frame edge is shown immediately
    if (frame_start) begin
      if (wr_buf_done) begin
        rd_d = wr_buf_idx;
        nv_d = 1'b0;
      end else if (new_valid) begin
        rd_d = newest_idx;
        nv_d = 1'b0;
      end
    end

    if (line_req && !frame_start) begin
      if (queue == 2'd2 || line_idx == Y_END) begin
        if (drop_cnt != 16'hFFFF)
          drop_d = drop_cnt + 16'd1;
      end else begin
        q_d = queue + 2'd1;
      end
    end

    unique case (state)
      IDLE: begin
        // q_d already holds this cycle's request: saves a cycle
        if (!frame_start && q_d != 2'd0 && line_idx < Y_END)
          state_d = WAIT_CREDIT;
      end
      WAIT_CREDIT: begin
        if (frame_start) begin
          state_d = IDLE;
        end else if (burst != '0) begin
          addr_d  = line_addr;
          num_d   = burst;
          kick_d  = 1'b1;
          state_d = KICK;
        end
      end
      KICK: begin
        if (busy) begin
          accept  = 1'b1;
          kick_d  = 1'b0;
          state_d = WAIT_BUSY_LOW;
          if (frame_start) abort_d = 1'b1;
        end else if (frame_start) begin
          kick_d  = 1'b0;
          state_d = IDLE;
        end
      end
      WAIT_BUSY_LOW: begin
        if (frame_start) abort_d = 1'b1;
        if (!busy) begin
          abort_d = 1'b0;
          if (abort || frame_start) begin
            state_d = IDLE;
          end else if (off_sum >= X_W) begin
            off_d   = '0;
            line_d  = line_idx + 12'd1;
            q_d     = q_d - 2'd1;
            state_d = IDLE;
          end else begin
            off_d   = off_sum;
            state_d = WAIT_CREDIT;
          end
        end
      end
    endcase

    if (frame_start) begin
      line_d = '0;
      off_d  = '0;
      q_d    = '0;
    end

    pend_d = pending;
    if (accept) pend_d = pending + 17'(read_num);
    if (buf_we && pend_d != '0) pend_d = pend_d - 17'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      kick       <= 1'b0;
      read_addr  <= '0;
      read_num   <= '0;
      rd_buf_idx <= '0;
      line_idx   <= '0;
      drop_cnt   <= '0;
      offset     <= '0;
      pending    <= '0;
      queue      <= '0;
      newest_idx <= '0;
      new_valid  <= 1'b0;
      abort      <= 1'b0;
    end else begin
      state      <= state_d;
      kick       <= kick_d;
      read_addr  <= addr_d;
      read_num   <= num_d;
      rd_buf_idx <= rd_d;
      line_idx   <= line_d;
      drop_cnt   <= drop_d;
      offset     <= off_d;
      pending    <= pend_d;
      queue      <= q_d;
      newest_idx <= newest_d;
      new_valid  <= nv_d;
      abort      <= abort_d;
    end
  end

endmodule

// File: tb/tb_frame_fetch_ctrl.sv
// tb_frame_fetch_ctrl: directed bench with request scoreboard.
// A second small instance covers the end-of-frame drop boundary.
module tb_frame_fetch_ctrl;

  logic        clk;
  logic        rst;
  logic        frame_start, line_req;
  logic        wr_buf_done;
  logic [0:0]  wr_buf_idx;
  logic [15:0] fifo_level;
  logic        buf_we;
  logic        kick, busy;
  logic [31:0] read_addr, read_num;
  logic [0:0]  rd_buf_idx;
  logic [11:0] line_idx;
  logic [15:0] drop_cnt;

  logic        fs2, lr2, kick2, busy2;
  logic [31:0] read_addr2, read_num2;
  logic [0:0]  rd_buf_idx2;
  logic [11:0] line_idx2;
  logic [15:0] drop_cnt2;
  logic        zero_b;
  logic [0:0]  zero_idx;
  logic [15:0] zero_lvl;

  logic echo_en, busy_hold;
  int   checks = 0;
  int   errors = 0;
  logic [63:0] sb[$];

  frame_fetch_ctrl dut (
    .clk(clk), .rst(rst),
    .frame_start(frame_start), .line_req(line_req),
    .wr_buf_done(wr_buf_done), .wr_buf_idx(wr_buf_idx),
    .fifo_level(fifo_level), .buf_we(buf_we),
    .kick(kick), .busy(busy),
    .read_addr(read_addr), .read_num(read_num),
    .rd_buf_idx(rd_buf_idx), .line_idx(line_idx),
    .drop_cnt(drop_cnt)
  );

  frame_fetch_ctrl #(.X_SIZE(8), .Y_SIZE(3)) dut2 (
    .clk(clk), .rst(rst),
    .frame_start(fs2), .line_req(lr2),
    .wr_buf_done(zero_b), .wr_buf_idx(zero_idx),
    .fifo_level(zero_lvl), .buf_we(zero_b),
    .kick(kick2), .busy(busy2),
    .read_addr(read_addr2), .read_num(read_num2),
    .rd_buf_idx(rd_buf_idx2), .line_idx(line_idx2),
    .drop_cnt(drop_cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // DRAM side responder: busy follows kick one cycle later
  always @(posedge clk) begin
    busy  <= busy_hold | (echo_en & kick);
    busy2 <= kick2;
  end

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // every accepted request is checked against the scoreboard
  always @(negedge clk) begin
    if (rst && kick && busy) begin
      logic [63:0] e;
      e = (sb.size() > 0) ? sb.pop_front() : '1;
      check("req", {read_addr, read_num}, e);
    end
  end

  task automatic exp_line(input int b, input int ln, input int off0);
    int off;
    int n;
    off = off0;
    while (off < 1600) begin
      n = (1600 - off > 256) ? 256 : 1600 - off;
      sb.push_back({32'(b * 32'h0060_0000 + (ln * 1600 + off) * 4),
                    32'(n)});
      off += n;
    end
  endtask

  task automatic wait_line(input logic [11:0] tgt, input string tag);
    int n;
    n = 0;
    while (line_idx !== tgt && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check(tag, 64'(line_idx), 64'(tgt));
  endtask

  task automatic drain(input int n);
    buf_we = 1'b1;
    repeat (n) @(negedge clk);
    buf_we = 1'b0;
  endtask

  task automatic pulse_fs();
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  task automatic pulse_lr();
    line_req = 1'b1;
    @(negedge clk);
    line_req = 1'b0;
  endtask

  initial begin
    int n;
    rst = 1'b0;
    frame_start = 0; line_req = 0;
    wr_buf_done = 0; wr_buf_idx = '0;
    fifo_level = '0; buf_we = 0;
    echo_en = 1'b1; busy_hold = 1'b0;
    fs2 = 0; lr2 = 0;
    zero_b = 0; zero_idx = '0; zero_lvl = '0;
    repeat (3) @(negedge clk);
    check("rst_kick", 64'(kick), 0);
    check("rst_addr", 64'(read_addr), 0);
    check("rst_num", 64'(read_num), 0);
    check("rst_line", 64'(line_idx), 0);
    check("rst_drop", 64'(drop_cnt), 0);
    check("rst_kick2", 64'(kick2), 0);
    rst = 1'b1;
    @(negedge clk);

    // full line, ample credit: 6x256 + 64
    pulse_fs();
    exp_line(0, 0, 0);
    line_req = 1'b1;
    @(negedge clk);
    line_req = 1'b0;
    check("lat_c1", 64'(kick), 0);
    @(negedge clk);
    check("lat_c2", 64'(kick), 1);
    wait_line(12'd1, "line1");
    check("sb_l1", 64'(sb.size()), 0);
    drain(1700);

    // credit-limited first burst then stall
    fifo_level = 16'd8000;
    sb.push_back({32'h0000_1900, 32'd192});
    pulse_lr();
    repeat (30) @(negedge clk);
    check("stall_kick", 64'(kick), 0);
    check("stall_num", 64'(read_num), 192);
    check("stall_line", 64'(line_idx), 1);
    exp_line(0, 1, 192);
    fifo_level = 16'd0;
    wait_line(12'd2, "line2");
    drain(1700);

    // buffer handoff
    wr_buf_idx = 1'b1;
    wr_buf_done = 1'b1;
    @(negedge clk);
    wr_buf_done = 1'b0;
    pulse_fs();
    check("buf1_rd", 64'(rd_buf_idx), 1);
    check("buf1_line", 64'(line_idx), 0);
    exp_line(1, 0, 0);
    pulse_lr();
    wait_line(12'd1, "buf1_l0");
    drain(1700);
    pulse_fs();
    check("repeat_rd", 64'(rd_buf_idx), 1);
    wr_buf_idx = 1'b0;
    wr_buf_done = 1'b1;
    frame_start = 1'b1;
    @(negedge clk);
    wr_buf_done = 1'b0;
    frame_start = 1'b0;
    check("coinc_rd", 64'(rd_buf_idx), 0);

    // queue saturation with busy held low
    echo_en = 1'b0;
    line_req = 1'b1;
    repeat (3) @(negedge clk);
    line_req = 1'b0;
    check("drop_q", 64'(drop_cnt), 1);
    exp_line(0, 0, 0);
    exp_line(0, 1, 0);
    echo_en = 1'b1;
    wait_line(12'd2, "q2_lines");
    repeat (10) @(negedge clk);
    check("q2_stop", 64'(line_idx), 2);
    check("q2_kick", 64'(kick), 0);
    drain(3300);

    // frame_start aborts an unaccepted kick
    echo_en = 1'b0;
    pulse_lr();
    n = 0;
    while (!kick && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("ab_kick", 64'(kick), 1);
    check("ab_addr", 64'(read_addr), 32'h0000_3200);
    wr_buf_idx = 1'b1;
    wr_buf_done = 1'b1;
    @(negedge clk);
    wr_buf_done = 1'b0;
    pulse_fs();
    check("ab_kick0", 64'(kick), 0);
    check("ab_line", 64'(line_idx), 0);
    check("ab_rd", 64'(rd_buf_idx), 1);
    // exact-fit credit proves the abort added nothing to pending
    fifo_level = 16'd7936;
    busy_hold = 1'b1;
    echo_en = 1'b1;
    sb.push_back({32'h0060_0000, 32'd256});
    pulse_lr();
    repeat (8) @(negedge clk);
    check("hold_kick", 64'(kick), 0);
    check("hold_addr", 64'(read_addr), 32'h0060_0000);

    // reset in the middle of the busy wait
    rst = 1'b0;
    @(negedge clk);
    check("mr_kick", 64'(kick), 0);
    check("mr_addr", 64'(read_addr), 0);
    check("mr_num", 64'(read_num), 0);
    check("mr_rd", 64'(rd_buf_idx), 0);
    check("mr_line", 64'(line_idx), 0);
    check("mr_drop", 64'(drop_cnt), 0);
    rst = 1'b1;
    busy_hold = 1'b0;
    fifo_level = 16'd0;
    @(negedge clk);
    exp_line(0, 0, 0);
    pulse_lr();
    wait_line(12'd1, "post_rst");
    check("sb_end", 64'(sb.size()), 0);

    // small frame: request beyond the last line is dropped
    fs2 = 1'b1;
    @(negedge clk);
    fs2 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      lr2 = 1'b1;
      @(negedge clk);
      lr2 = 1'b0;
      n = 0;
      while (line_idx2 !== 12'(i + 1) && n < 50) begin
        @(negedge clk);
        n++;
      end
      check("s_line", 64'(line_idx2), 64'(i + 1));
    end
    lr2 = 1'b1;
    @(negedge clk);
    lr2 = 1'b0;
    repeat (5) @(negedge clk);
    check("s_drop", 64'(drop_cnt2), 1);
    check("s_kick", 64'(kick2), 0);
    check("s_line3", 64'(line_idx2), 3);
    check("s_addr", 64'(read_addr2), 32'h40);
    check("s_num", 64'(read_num2), 8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/frame_fetch_ctrl.md
FRAME_FETCH_CTRL -- requirements
Module: frame_fetch_ctrl

Interface
REQ-001 SHALL have parameter X_SIZE, default 1600, pixels (32-bit words) per line.
REQ-002 SHALL have parameter Y_SIZE, default 900, lines per frame.
REQ-003 SHALL have parameter NUM_BUFS, default 2, frame buffers in DRAM (2..8); BUF_W = clog2(NUM_BUFS), minimum 1.
REQ-004 SHALL have parameter BASE_ADDR, default 32'h0000_0000, byte address of buffer 0.
REQ-005 SHALL have parameter FRAME_STRIDE, default 32'h0060_0000, byte distance between buffers.
REQ-006 SHALL have parameter MAX_BURST, default 256, maximum words per read request.
REQ-007 SHALL have parameter FIFO_DEPTH, default 8192, pixel FIFO capacity in words.
REQ-008 SHALL have port clk, input, 1, single clock; all logic rising-edge.
REQ-009 SHALL have port rst, input, 1; reset is synchronous and active-low.
REQ-010 SHALL have ports frame_start and line_req, input, 1 each, one-cycle pulses already synchronised to clk.
REQ-011 SHALL have ports wr_buf_done (input, 1) and wr_buf_idx (input, BUF_W): writer finished the frame in buffer wr_buf_idx.
REQ-012 SHALL have port fifo_level, input, 16: current pixel FIFO fill in words.
REQ-013 SHALL have port buf_we, input, 1: one returned DRAM word per cycle high.
REQ-014 SHALL have ports kick (output, 1) and busy (input, 1): DRAM read request handshake.
REQ-015 SHALL have ports read_addr and read_num, output, 32 each: byte address and word count of request.
REQ-016 SHALL have ports rd_buf_idx (output, BUF_W), line_idx (output, 12), drop_cnt (output, 16): buffer being displayed, next line to fetch, dropped line requests.

Function
REQ-017 SHALL implement states IDLE, WAIT_CREDIT, KICK, WAIT_BUSY_LOW.
REQ-018 SHALL latch wr_buf_idx into newest_idx and set new_valid on wr_buf_done.
REQ-019 SHALL, on frame_start, load rd_buf_idx <= newest_idx and clear new_valid if new_valid, else keep rd_buf_idx (repeat frame); line_idx <= 0, word offset <= 0, line request queue cleared.
REQ-020 SHALL, if wr_buf_done and frame_start coincide, use the incoming wr_buf_idx for rd_buf_idx.
REQ-021 SHALL hold a line request queue saturating at 2; line_req when queue full or line_idx == Y_SIZE increments drop_cnt (saturating at 16'hFFFF).
REQ-022 SHALL leave IDLE to WAIT_CREDIT when queue non-empty and line_idx < Y_SIZE.
REQ-023 SHALL compute credit = FIFO_DEPTH - fifo_level - pending (pending per REQ-027), zero-clamped, and burst = min(MAX_BURST, X_SIZE - offset, credit).
REQ-024 SHALL stay in WAIT_CREDIT while burst == 0; else register read_num <= burst, read_addr <= BASE_ADDR + rd_buf_idx*FRAME_STRIDE + (line_idx*X_SIZE + offset)*4 (32-bit wrap), go to KICK.
REQ-025 SHALL hold kick high in KICK with read_addr/read_num stable; acceptance is the cycle kick && busy; next cycle kick = 0, state WAIT_BUSY_LOW.
REQ-026 SHALL, in WAIT_BUSY_LOW once busy == 0, add read_num to offset; if offset reaches X_SIZE, offset <= 0, line_idx += 1, queue -= 1, go IDLE; else go WAIT_CREDIT.
REQ-027 SHALL track pending (17 bit): + read_num on acceptance, - 1 per buf_we, both in one cycle allowed; never below 0.
REQ-028 SHALL, on frame_start in WAIT_CREDIT or KICK (not yet accepted), drop kick in the same cycle's next edge and go IDLE; in WAIT_BUSY_LOW complete the busy wait then go IDLE without offset/line update.
REQ-029 SHALL produce first kick 2 cycles after line_req in IDLE with sufficient credit (WAIT_CREDIT, KICK).

Reset
REQ-030 SHALL on rst == 0 at clk edge set kick 0, read_addr 0, read_num 0, rd_buf_idx 0, line_idx 0, drop_cnt 0, pending 0, queue 0, new_valid 0, state IDLE, overriding all other inputs including mid-handshake.

Verification
REQ-031 SHALL cover: defaults, fifo_level 0, frame_start then line_req, busy echo 1 cycle after kick -> 7 requests: 6 x 256 words, 1 x 64, addresses 0x0, 0x400 ... 0x1800; line_idx 1.
REQ-032 SHALL cover: fifo_level 8000, pending 0, line_req -> read_num 192; until fifo_level drops, WAIT_CREDIT with kick 0.
REQ-033 SHALL cover: wr_buf_done idx 1 then frame_start -> rd_buf_idx 1, first read_addr 0x0060_0000; next frame_start without wr_buf_done -> rd_buf_idx remains 1.
REQ-034 SHALL cover: 3 line_req pulses in 3 cycles with busy held 0 -> queue 2, drop_cnt 1; 901st request in a frame also increments drop_cnt.
REQ-035 SHALL cover: frame_start while kick high, busy 0 -> kick 0 next cycle, line_idx 0, no pending change.
REQ-036 SHALL cover: rst low during WAIT_BUSY_LOW -> all outputs at reset values next cycle; after release, normal fetch from line 0.
